mic1_mem_ctrl: RTL and testbench
================================

Name: mic1_mem_ctrl

Overview:
Memory controller and arbiter between the mic1 core and one shared single-port word RAM. It serializes the core's data write, data read and instruction-byte fetch into RAM accesses, and stalls the core through its `run` input until results are ready. It also shares the RAM with a host loader/debug port, so programs and data can be loaded while the core is halted and inspected while it runs.

Parameters:
ADDR_W, 16, RAM word-address width; core and host addresses are truncated to ADDR_W bits.
RAM_LATENCY, 1, cycles from the ram_en cycle to valid ram_rdata; legal range 1..7.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
go  in  1  core enable; when 0, run is held at 0 and the core is frozen
core_addr  in  32  data word address (MAR)
core_wdata  in  32  write data (MDR)
core_read  in  1  data read request, level
core_write  in  1  data write request, level
core_fetch  in  1  instruction fetch request, level
core_addr_instr  in  32  fetch byte address (PC)
core_rdata  out  32  read result (to mem_rdata)
core_rd_instr  out  8  fetched byte (to mem_rd_instr)
run  out  1  core advance enable
host_req  in  1  host access request, held until host_ack
host_we  in  1  host write when 1, read when 0
host_addr  in  ADDR_W  host word address
host_wdata  in  32  host write data
host_rdata  out  32  host read result, valid while host_ack=1
host_ack  out  1  one-cycle completion pulse
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable, qualified by ram_en
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE.
  - run=0, ram_en=0, ram_we=0, host_ack=0.
  - core_rdata=0, core_rd_instr=0, host_rdata=0, ram_addr=0, ram_wdata=0.
  - pending mask cleared, latency counter=0, host_turn=0.
  - Reset mid-access aborts it; no ram_en is issued after reset is seen.
- FSM states: IDLE, ISSUE, WAIT, DONE, HOST_ISSUE, HOST_WAIT.
- IDLE:
  - run (combinational) = go & ~(core_read|core_write|core_fetch).
  - Grant core if go & any core request & ~(host_turn & host_req). Latch the pending mask {write,read,fetch}, addresses and wdata, then go to ISSUE.
  - Otherwise grant host if host_req; go to HOST_ISSUE.
- Core service order: write, then read, then fetch, one RAM access each.
  - A write before a read to the same address makes the read return the new data.
- ISSUE: drive ram_en=1 for one cycle.
  - Write: ram_we=1, ram_addr=core_addr[ADDR_W-1:0], clear the write bit.
  - Read: ram_addr=core_addr.
  - Fetch: ram_addr=core_addr_instr[ADDR_W+1:2].
  - Write: go to ISSUE if bits remain, else DONE.
  - Read or fetch: go to WAIT with counter=1.
- WAIT: counter increments each cycle. In the cycle counter==RAM_LATENCY:
  - Read: capture core_rdata<=ram_rdata.
  - Fetch: capture core_rd_instr<=ram_rdata[8*a+7:8*a], where a=core_addr_instr[1:0] (little-endian lanes).
  - Clear the serviced bit; go to ISSUE if bits remain, else DONE.
- DONE: lasts one cycle.
  - run=go.
  - core_rdata and core_rd_instr stay stable until overwritten by a later access.
  - Set host_turn=host_req, then go to IDLE.
- If go=0 during DONE, the core does not consume the result and re-presents the same requests; the repeated access is permitted and harmless.
- Host path:
  - HOST_ISSUE drives ram_en, ram_we=host_we, ram_addr=host_addr, ram_wdata=host_wdata.
  - Host write: pulse host_ack next cycle.
  - Host read: wait RAM_LATENCY in HOST_WAIT, then latch host_rdata and pulse host_ack for one cycle.
  - Clear host_turn; return to IDLE. run=0 throughout.
- Fairness: after each core transaction a waiting host gets the next slot; neither side starves.
- Core stall length with no contention:
  - Write only: 2 cycles.
  - Read only: 2+RAM_LATENCY cycles.
  - Write+read+fetch: 1+1+2·(1+RAM_LATENCY) cycles.

Test Plan:
- Reset, then go=1 with no requests → run=1 every cycle; ram_en never asserted.
- Host writes 0xDEADBEEF @0x10, then core_read with core_addr=0x10, RAM_LATENCY=1 → run low exactly 3 cycles, core_rdata=0xDEADBEEF in the DONE cycle.
- RAM word @0x4 = 0x44332211; core_fetch with core_addr_instr=0x12 → ram_addr=0x4, core_rd_instr=0x33; with addr 0x13 → 0x44.
- core_write+core_read, same cycle, addr 0x20, wdata 0x5 → ram accesses ordered write then read; core_rdata=0x5; run low 4 cycles.
- Core issuing a read every transaction while host_req held for a read → host_ack within two core transactions; host_rdata correct; no lost core data.
- resetn pulsed low during WAIT with RAM_LATENCY=3 → all outputs return to reset values the next cycle; no further ram_en; the next core read completes normally.

Source files
------------

// File: rtl/mic1_mem_ctrl.sv
// Arbiter and sequencer between the mic1 core, a host loader port and one
// shared single-port RAM. The core is stalled through run until its accesses finish.
module mic1_mem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              go,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    input  logic              core_read,
    input  logic              core_write,
    input  logic              core_fetch,
    input  logic [31:0]       core_addr_instr,
    output logic [31:0]       core_rdata,
    output logic [7:0]        core_rd_instr,
    output logic              run,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic [31:0]       host_rdata,
    output logic              host_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_HISSUE = 3'd4;
    localparam logic [2:0] S_HWAIT  = 3'd5;

    logic [2:0]        state;
    logic [2:0]        pend;      // {write, read, fetch} still to be serviced
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] iaddr_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic [2:0]        cnt;
    logic              host_turn;
    logic              core_req;
    logic              core_grant;
    logic              host_grant;
    logic              lat_hit;
    logic              unused_addr_bits;

    assign core_req   = core_read | core_write | core_fetch;
    assign core_grant = go & core_req & ~(host_turn & host_req);
    // host_req is still high in the ack cycle; it must not start a second access
    assign host_grant = host_req & ~host_ack;
    assign lat_hit    = (cnt == 3'(RAM_LATENCY));
    assign unused_addr_bits = ^{core_addr[31:ADDR_W], core_addr_instr[31:ADDR_W+2]};

    always_comb begin
        run       = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            S_IDLE: run = go & ~core_req;
            S_ISSUE: begin
                ram_en = 1'b1;
                if (pend[2]) begin
                    ram_we    = 1'b1;
                    ram_addr  = addr_q;
                    ram_wdata = wdata_q;
                end else if (pend[1]) begin
                    ram_addr = addr_q;
                end else begin
                    ram_addr = iaddr_q;
                end
            end
            S_DONE: run = go;
            S_HISSUE: begin
                ram_en    = 1'b1;
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            pend          <= '0;
            addr_q        <= '0;
            iaddr_q       <= '0;
            lane_q        <= '0;
            wdata_q       <= '0;
            cnt           <= '0;
            host_turn     <= 1'b0;
            host_ack      <= 1'b0;
            host_rdata    <= '0;
            core_rdata    <= '0;
            core_rd_instr <= '0;
        end else begin
            host_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (core_grant) begin
                        pend    <= {core_write, core_read, core_fetch};
                        addr_q  <= core_addr[ADDR_W-1:0];
                        iaddr_q <= core_addr_instr[ADDR_W+1:2];
                        lane_q  <= core_addr_instr[1:0];
                        wdata_q <= core_wdata;
                        state   <= S_ISSUE;
                    end else if (host_grant) begin
                        state <= S_HISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pend[2]) begin
                        pend[2] <= 1'b0;
                        state   <= (pend[1] | pend[0]) ? S_ISSUE : S_DONE;
                    end else begin
                        cnt   <= 3'd1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_hit) begin
                        // read always precedes fetch, so pend[1] tells which one is in flight
                        if (pend[1]) begin
                            core_rdata <= ram_rdata;
                            pend[1]    <= 1'b0;
                            state      <= pend[0] ? S_ISSUE : S_DONE;
                        end else begin
                            core_rd_instr <= ram_rdata[8*lane_q +: 8];
                            pend[0]       <= 1'b0;
                            state         <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    host_turn <= host_req;
                    state     <= S_IDLE;
                end
                S_HISSUE: begin
                    host_turn <= 1'b0;
                    if (host_we) begin
                        host_ack <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt   <= 3'd1;
                        state <= S_HWAIT;
                    end
                end
                S_HWAIT: begin
                    if (lat_hit) begin
                        host_rdata <= ram_rdata;
                        host_ack   <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Two controllers (RAM latency 1 and 3), each with its own RAM, checked against
// a word-array reference model of memory contents, access order and stall length.
module tb_mic1_mem_ctrl;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        go, c_read, c_write, c_fetch, run;
    logic [NI-1:0][31:0]  c_addr, c_wdata, c_pc, c_rdata;
    logic [NI-1:0][7:0]   c_instr;
    logic [NI-1:0]        h_req, h_we, h_ack;
    logic [NI-1:0][15:0]  h_addr, r_addr;
    logic [NI-1:0][31:0]  h_wdata, h_rdata, r_wdata, r_rdata;
    logic [NI-1:0]        r_en, r_we;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mic1_mem_ctrl #(.ADDR_W(16), .RAM_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .resetn(resetn), .go(go[g]),
            .core_addr(c_addr[g]), .core_wdata(c_wdata[g]),
            .core_read(c_read[g]), .core_write(c_write[g]), .core_fetch(c_fetch[g]),
            .core_addr_instr(c_pc[g]), .core_rdata(c_rdata[g]), .core_rd_instr(c_instr[g]),
            .run(run[g]),
            .host_req(h_req[g]), .host_we(h_we[g]), .host_addr(h_addr[g]),
            .host_wdata(h_wdata[g]), .host_rdata(h_rdata[g]), .host_ack(h_ack[g]),
            .ram_en(r_en[g]), .ram_we(r_we[g]), .ram_addr(r_addr[g]),
            .ram_wdata(r_wdata[g]), .ram_rdata(r_rdata[g])
        );
    end

    function automatic logic [31:0] ram_init(int a);
        return 32'(32'h9E37_79B9 * 32'(a + 1));
    endfunction

    // RAM environment: contents stored as XOR against a power-up pattern
    bit   [31:0] ram_delta [NI][256];
    logic [31:0] rpipe     [NI][8];
    int          acc_tot   [NI];
    logic        acc_we_l  [NI][64];
    logic [15:0] acc_addr_l[NI][64];
    logic [31:0] acc_wd_l  [NI][64];

    always @(posedge clk) begin
        for (int d = 0; d < NI; d++) begin
            if (r_en[d]) begin
                acc_we_l[d][acc_tot[d] % 64]   <= r_we[d];
                acc_addr_l[d][acc_tot[d] % 64] <= r_addr[d];
                acc_wd_l[d][acc_tot[d] % 64]   <= r_wdata[d];
                acc_tot[d] <= acc_tot[d] + 1;
                if (r_we[d])
                    ram_delta[d][r_addr[d][7:0]] <= r_wdata[d] ^ ram_init(int'(r_addr[d][7:0]));
            end
            rpipe[d][0] <= ram_delta[d][r_addr[d][7:0]] ^ ram_init(int'(r_addr[d][7:0]));
            for (int k = 1; k < 8; k++) rpipe[d][k] <= rpipe[d][k-1];
        end
    end
    assign r_rdata[0] = rpipe[0][0];
    assign r_rdata[1] = rpipe[1][2];

    logic [31:0] ref_mem [NI][256];
    int n_cmp = 0;
    int n_err = 0;

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_txn(input int d, input bit w, input bit r, input bit f,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] pc, input bit solo);
        int          start, stall, ne, exp_stall;
        logic        e_we   [3];
        logic [15:0] e_addr [3];
        logic [31:0] e_wd   [3];
        logic [31:0] exp_rd, word;
        logic [7:0]  exp_b;
        ne = 0;
        exp_rd = '0;
        exp_b = '0;
        if (w) begin
            ref_mem[d][addr[7:0]] = wdata;
            e_we[ne] = 1'b1; e_addr[ne] = addr[15:0]; e_wd[ne] = wdata; ne++;
        end
        if (r) begin
            exp_rd = ref_mem[d][addr[7:0]];
            e_we[ne] = 1'b0; e_addr[ne] = addr[15:0]; e_wd[ne] = '0; ne++;
        end
        if (f) begin
            word  = ref_mem[d][pc[9:2]];
            exp_b = 8'(word >> (8 * pc[1:0]));
            e_we[ne] = 1'b0; e_addr[ne] = pc[17:2]; e_wd[ne] = '0; ne++;
        end
        exp_stall = 1 + (w ? 1 : 0) + (r ? 1 + lat(d) : 0) + (f ? 1 + lat(d) : 0);
        start = acc_tot[d];
        c_write[d] = w; c_read[d] = r; c_fetch[d] = f;
        c_addr[d] = addr; c_wdata[d] = wdata; c_pc[d] = pc;
        stall = 0;
        do begin
            @(negedge clk);
            if (!run[d]) stall++;
        end while (!run[d] && stall < 100);
        if (!run[d]) begin
            n_cmp++; n_err++;
            $error("FAIL core_timeout[%0d]: run still low after %0d cycles, required high", d, stall);
        end else begin
            if (solo) chk($sformatf("stall[%0d] wrf=%0d%0d%0d", d, w, r, f), stall, exp_stall);
            if (r) chk($sformatf("core_rdata[%0d] @%h", d, addr[15:0]), c_rdata[d], exp_rd);
            if (f) chk($sformatf("core_rd_instr[%0d] pc=%h", d, pc), {24'h0, c_instr[d]}, {24'h0, exp_b});
        end
        step();
        c_write[d] = 1'b0; c_read[d] = 1'b0; c_fetch[d] = 1'b0;
        if (solo) begin
            chk($sformatf("ram_access_count[%0d]", d), acc_tot[d] - start, ne);
            for (int i = 0; i < ne && i < acc_tot[d] - start; i++) begin
                chk($sformatf("ram_we[%0d] #%0d", d, i), {31'h0, acc_we_l[d][(start + i) % 64]}, {31'h0, e_we[i]});
                chk($sformatf("ram_addr[%0d] #%0d", d, i), {16'h0, acc_addr_l[d][(start + i) % 64]}, {16'h0, e_addr[i]});
                if (e_we[i]) chk($sformatf("ram_wdata[%0d] #%0d", d, i), acc_wd_l[d][(start + i) % 64], e_wd[i]);
            end
        end
    endtask

    task automatic host_txn(input int d, input bit we, input logic [15:0] a,
                            input logic [31:0] wd);
        int waited;
        logic [31:0] exp;
        exp = ref_mem[d][a[7:0]];
        if (we) ref_mem[d][a[7:0]] = wd;
        h_req[d] = 1'b1; h_we[d] = we; h_addr[d] = a; h_wdata[d] = wd;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!h_ack[d] && waited < 100);
        if (!h_ack[d]) begin
            n_cmp++; n_err++;
            $error("FAIL host_timeout[%0d]: no host_ack after %0d cycles", d, waited);
        end else if (!we) begin
            chk($sformatf("host_rdata[%0d] @%h", d, a), h_rdata[d], exp);
        end
        step();
        h_req[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("host_ack_pulse[%0d]", d), {31'h0, h_ack[d]}, 32'h0);
        step();
    endtask

    task automatic check_reset_state(input int d);
        chk($sformatf("rst run[%0d]", d), {31'h0, run[d]}, 32'h0);
        chk($sformatf("rst ram_en[%0d]", d), {31'h0, r_en[d]}, 32'h0);
        chk($sformatf("rst ram_we[%0d]", d), {31'h0, r_we[d]}, 32'h0);
        chk($sformatf("rst host_ack[%0d]", d), {31'h0, h_ack[d]}, 32'h0);
        chk($sformatf("rst core_rdata[%0d]", d), c_rdata[d], 32'h0);
        chk($sformatf("rst core_rd_instr[%0d]", d), {24'h0, c_instr[d]}, 32'h0);
        chk($sformatf("rst host_rdata[%0d]", d), h_rdata[d], 32'h0);
        chk($sformatf("rst ram_addr[%0d]", d), {16'h0, r_addr[d]}, 32'h0);
        chk($sformatf("rst ram_wdata[%0d]", d), r_wdata[d], 32'h0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int host_seen, core_done, start;
        logic [31:0] ra, rb;
        for (int d = 0; d < NI; d++)
            for (int a = 0; a < 256; a++) ref_mem[d][a] = ram_init(a);
        go = '0; c_read = '0; c_write = '0; c_fetch = '0;
        c_addr = '0; c_wdata = '0; c_pc = '0;
        h_req = '0; h_we = '0; h_addr = '0; h_wdata = '0;

        resetn = 1'b0;
        repeat (3) step();
        for (int d = 0; d < NI; d++) check_reset_state(d);
        resetn = 1'b1;
        go = '1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("idle run cyc%0d", i), {30'h0, run}, 32'h3);
        end
        step();
        chk("idle no ram_en [0]", acc_tot[0], 0);
        chk("idle no ram_en [1]", acc_tot[1], 0);

        host_txn(0, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        core_txn(0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b1);
        chk("read after host write", c_rdata[0], 32'hDEAD_BEEF);

        host_txn(0, 1'b1, 16'h0004, 32'h4433_2211);
        core_txn(0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0012, 1'b1);
        chk("fetch pc 0x12", {24'h0, c_instr[0]}, 32'h33);
        core_txn(0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0013, 1'b1);
        chk("fetch pc 0x13", {24'h0, c_instr[0]}, 32'h44);

        core_txn(0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h5, 32'h0, 1'b1);
        chk("write then read 0x20", c_rdata[0], 32'h5);

        core_done = 0;
        host_seen = -1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    core_txn(0, 1'b0, 1'b1, 1'b0, {24'h0, 8'(64 + i)}, 32'h0, 32'h0, 1'b0);
                    core_done++;
                end
            end
            begin
                step();
                host_txn(0, 1'b0, 16'h0030, 32'h0);
                host_seen = core_done;
            end
        join
        chk("host served within two core txns", {31'h0, host_seen >= 0 && host_seen <= 2}, 32'h1);

        for (int d = 0; d < NI; d++) begin
            for (int i = 0; i < 30; i++) begin
                bit [2:0] m;
                m  = 3'($urandom_range(1, 7));
                ra = $urandom();
                rb = $urandom();
                core_txn(d, m[2], m[1], m[0],
                         {ra[31:16], 8'h00, 8'($urandom_range(0, 255))}, $urandom(),
                         {rb[31:18], 8'h00, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))}, 1'b1);
                if (i % 4 == 3)
                    host_txn(d, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), $urandom());
            end
        end

        start = acc_tot[1];
        c_read[1] = 1'b1;
        c_addr[1] = 32'h0000_0050;
        step();
        step();
        resetn = 1'b0;
        step();
        check_reset_state(1);
        c_read[1] = 1'b0;
        resetn = 1'b1;
        repeat (6) step();
        chk("no ram_en after reset", acc_tot[1] - start, 1);
        core_txn(1, 1'b0, 1'b1, 1'b0, 32'h0000_0050, 32'h0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
